// File: rtl/instr_encoder_if.sv
// Field-bundle handshake and instruction-memory write port of the instruction encoder.
// The encoder sits on the slave side; the loader/memory environment sits on the master side.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            fmt;
  logic [5:0]            opcode;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [31:0]           target;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J/branch fields into 32-bit words and writes them sequentially into
// instruction memory, tracking the byte PC of the next slot for branch/jump encoding.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_encoder_if.slave      bus,
  output logic [31:0]         pc,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                error,
  output logic [1:0]          err_code
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state, state_n;
  logic [31:0]        pc_nxt;
  logic [31:0]        diff;
  logic signed [31:0] off;
  logic [31:0]        word;
  logic [1:0]         fault;
  logic               accept;

  assign pc_nxt = pc + 32'd4;
  assign diff   = bus.target - pc_nxt;
  assign off    = $signed(diff) >>> 2;

  // count never exceeds 2^ADDR_WIDTH, so its top bit alone flags a full memory
  assign full         = count[ADDR_WIDTH];
  assign bus.in_ready = (state == IDLE) && !full;
  assign bus.mem_we   = (state == WRITE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    word  = 32'h0;
    fault = 2'b00;
    case (bus.fmt)
      2'b00: word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      2'b01: word = {bus.opcode, bus.rs, bus.rt, bus.imm};
      2'b10: begin
        word = {bus.opcode, bus.target[27:2]};
        if (bus.target[31:28] != pc_nxt[31:28]) fault = 2'b10;
      end
      default: begin
        word = {bus.opcode, bus.rs, bus.rt, off[15:0]};
        // offset fits in 16 bits only if bits 31..15 are a pure sign extension
        if (off[31:15] != {17{off[15]}}) fault = 2'b01;
      end
    endcase
    if (bus.fmt[1] && (bus.target[1:0] != 2'b00)) fault = 2'b11;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && (fault == 2'b00)) state_n = WRITE;
      WRITE:   if (bus.mem_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      count         <= '0;
      pc            <= BASE_ADDR;
      error         <= 1'b0;
      err_code      <= 2'b00;
    end else begin
      state <= state_n;
      if (accept) begin
        if (fault != 2'b00) begin
          error <= 1'b1;
          if (!error) err_code <= fault;
        end else begin
          bus.mem_addr  <= count[ADDR_WIDTH-1:0];
          bus.mem_wdata <= word;
        end
      end
      if ((state == WRITE) && bus.mem_ack) begin
        count <= count + 1'b1;
        pc    <= pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a large (256-word) and a tiny (4-word) encoder share one stimulus
// stream and are both checked every cycle against a behavioural loader model.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  fmt = 2'b00;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [31:0] target = '0;
  logic        ack = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(8)) b0 ();
  instr_encoder_if #(.ADDR_WIDTH(2)) b1 ();

  assign b0.in_valid = in_valid; assign b1.in_valid = in_valid;
  assign b0.fmt = fmt;           assign b1.fmt = fmt;
  assign b0.opcode = opcode;     assign b1.opcode = opcode;
  assign b0.rs = rs;             assign b1.rs = rs;
  assign b0.rt = rt;             assign b1.rt = rt;
  assign b0.rd = rd;             assign b1.rd = rd;
  assign b0.shamt = shamt;       assign b1.shamt = shamt;
  assign b0.funct = funct;       assign b1.funct = funct;
  assign b0.imm = imm;           assign b1.imm = imm;
  assign b0.target = target;     assign b1.target = target;
  assign b0.mem_ack = ack;       assign b1.mem_ack = ack;

  logic [31:0] pc0, pc1;
  logic [8:0]  count0;
  logic [2:0]  count1;
  logic        full0, full1, error0, error1;
  logic [1:0]  code0, code1;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(b0), .pc(pc0), .count(count0),
    .full(full0), .error(error0), .err_code(code0));

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(32'h0)) dut_s (
    .clk(clk), .rst(rst), .bus(b1), .pc(pc1), .count(count1),
    .full(full1), .error(error1), .err_code(code1));

  // DUT outputs gathered into arrays so one compare loop covers both instances
  logic [31:0] a_rdy[2], a_we[2], a_addr[2], a_wdata[2], a_pc[2], a_cnt[2], a_full[2], a_err[2], a_code[2];
  assign a_rdy[0] = {31'b0, b0.in_ready};     assign a_rdy[1] = {31'b0, b1.in_ready};
  assign a_we[0] = {31'b0, b0.mem_we};        assign a_we[1] = {31'b0, b1.mem_we};
  assign a_addr[0] = {24'b0, b0.mem_addr};    assign a_addr[1] = {30'b0, b1.mem_addr};
  assign a_wdata[0] = b0.mem_wdata;           assign a_wdata[1] = b1.mem_wdata;
  assign a_pc[0] = pc0;                       assign a_pc[1] = pc1;
  assign a_cnt[0] = {23'b0, count0};          assign a_cnt[1] = {29'b0, count1};
  assign a_full[0] = {31'b0, full0};          assign a_full[1] = {31'b0, full1};
  assign a_err[0] = {31'b0, error0};          assign a_err[1] = {31'b0, error1};
  assign a_code[0] = {30'b0, code0};          assign a_code[1] = {30'b0, code1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Encoding from the instruction-format rules; returns {error code, word}.
  function automatic logic [33:0] encode(input logic [31:0] p);
    logic [31:0] np, w;
    logic [15:0] o16;
    logic [1:0]  c;
    int          o;
    np = p + 32'd4;
    o  = $signed(target - np) >>> 2;
    o16 = o[15:0];
    c  = 2'b00;
    w  = 32'h0;
    case (fmt)
      2'b00: w = {opcode, rs, rt, rd, shamt, funct};
      2'b01: w = {opcode, rs, rt, imm};
      2'b10: begin
        w = {opcode, target[27:2]};
        if (target[31:28] != np[31:28]) c = 2'b10;
      end
      default: begin
        w = {opcode, rs, rt, o16};
        if (o < -32768 || o > 32767) c = 2'b01;
      end
    endcase
    if (fmt[1] && target[1:0] != 2'b00) c = 2'b11;
    return {c, w};
  endfunction

  int          cap[2] = '{256, 4};
  bit          m_busy[2], m_err[2];
  int          m_cnt[2], m_addr[2];
  logic [31:0] m_pc[2], m_wdata[2];
  logic [1:0]  m_code[2];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0; m_err[d] <= 1'b0; m_cnt[d] <= 0; m_addr[d] <= 0;
        m_pc[d] <= 32'h0; m_wdata[d] <= 32'h0; m_code[d] <= 2'b00;
      end else if (m_busy[d]) begin
        if (ack) begin
          m_busy[d] <= 1'b0;
          m_cnt[d]  <= m_cnt[d] + 1;
          m_pc[d]   <= m_pc[d] + 32'd4;
        end
      end else if (in_valid && m_cnt[d] != cap[d]) begin
        logic [33:0] e;
        e = encode(m_pc[d]);
        if (e[33:32] != 2'b00) begin
          m_err[d] <= 1'b1;
          if (!m_err[d]) m_code[d] <= e[33:32];
        end else begin
          m_busy[d]  <= 1'b1;
          m_addr[d]  <= m_cnt[d] % cap[d];
          m_wdata[d] <= e[31:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d.in_ready", d), a_rdy[d], {31'b0, !m_busy[d] && m_cnt[d] != cap[d]});
        chk($sformatf("d%0d.mem_we", d), a_we[d], {31'b0, m_busy[d]});
        if (m_busy[d]) begin
          chk($sformatf("d%0d.mem_addr", d), a_addr[d], m_addr[d]);
          chk($sformatf("d%0d.mem_wdata", d), a_wdata[d], m_wdata[d]);
        end
        chk($sformatf("d%0d.pc", d), a_pc[d], m_pc[d]);
        chk($sformatf("d%0d.count", d), a_cnt[d], m_cnt[d]);
        chk($sformatf("d%0d.full", d), a_full[d], {31'b0, m_cnt[d] == cap[d]});
        chk($sformatf("d%0d.error", d), a_err[d], {31'b0, m_err[d]});
        chk($sformatf("d%0d.err_code", d), a_code[d], {30'b0, m_code[d]});
      end
    end
  end

  int  small_writes = 0;
  logic small_we_q = 1'b0;
  always @(negedge clk) begin
    if (b1.mem_we && !small_we_q) small_writes++;
    small_we_q <= b1.mem_we;
  end

  // Drives one bundle and returns at the negedge right after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s, t, r,
                      input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im,
                      input logic [31:0] tg);
    bit ok = 1'b0;
    fmt = f; opcode = op; rs = s; rt = t; rd = r; shamt = sh; funct = fn; imm = im; target = tg;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (b0.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept_within_20");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks the write presented just after accept, then lets the held ack complete it.
  task automatic wr_chk(input string nm, input logic [31:0] addr, input logic [31:0] data);
    chk({nm, ".we"}, a_we[0], 32'd1);
    chk({nm, ".addr"}, a_addr[0], addr);
    chk({nm, ".wdata"}, a_wdata[0], data);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst.in_ready", a_rdy[0], 32'd1);
    chk("rst.mem_we", a_we[0], 32'd0);
    chk("rst.mem_addr", a_addr[0], 32'd0);
    chk("rst.mem_wdata", a_wdata[0], 32'd0);
    chk("rst.pc", a_pc[0], 32'h0);
    chk("rst.err_code", a_code[0], 32'd0);

    // R word held through three un-acked cycles
    send(2'b00, 6'd0, 5'd17, 5'd18, 5'd9, 5'd0, 6'h20, 16'h0, 32'h0);
    chk("r.wdata", a_wdata[0], 32'h0232_4820);
    chk("r.addr", a_addr[0], 32'd0);
    chk("r.in_ready", a_rdy[0], 32'd0);
    repeat (3) @(negedge clk);
    chk("r.hold_we", a_we[0], 32'd1);
    chk("r.hold_wdata", a_wdata[0], 32'h0232_4820);
    ack = 1'b1;
    @(negedge clk);
    chk("r.count", a_cnt[0], 32'd1);
    chk("r.pc", a_pc[0], 32'h4);
    chk("r.we_drop", a_we[0], 32'd0);

    send(2'b01, 6'h08, 5'd0, 5'd17, 5'd0, 5'd0, 6'd0, 16'd5, 32'h0);
    wr_chk("i", 32'd1, 32'h2011_0005);
    send(2'b11, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h18);
    wr_chk("br_fwd", 32'd2, 32'h1022_0003);
    send(2'b11, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0);
    wr_chk("br_back", 32'd3, 32'h1022_FFFC);
    chk("small.full", a_full[1], 32'd1);
    chk("small.in_ready", a_rdy[1], 32'd0);
    chk("small.count", a_cnt[1], 32'd4);

    send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h100);
    chk("small.no_we", a_we[1], 32'd0);
    wr_chk("j", 32'd4, 32'h0800_0040);
    send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h1000_0000);
    chk("jregion.we", a_we[0], 32'd0);
    chk("jregion.error", a_err[0], 32'd1);
    chk("jregion.code", a_code[0], 32'd2);
    send(2'b11, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h6);
    chk("misalign.we", a_we[0], 32'd0);
    chk("misalign.code_kept", a_code[0], 32'd2);
    chk("misalign.count", a_cnt[0], 32'd5);
    repeat (2) @(negedge clk);
    chk("small.writes", small_writes, 32'd4);

    // reset in the middle of an un-acked write
    ack = 1'b0;
    send(2'b01, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hBEEF, 32'h0);
    chk("mid.we", a_we[0], 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.we", a_we[0], 32'd0);
    chk("arst.count", a_cnt[0], 32'd0);
    chk("arst.pc", a_pc[0], 32'h0);
    chk("arst.in_ready", a_rdy[0], 32'd1);
    chk("arst.error", a_err[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;

    send(2'b11, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0002_0004);
    chk("brange.we", a_we[0], 32'd0);
    chk("brange.error", a_err[0], 32'd1);
    chk("brange.code", a_code[0], 32'd1);
    chk("brange.count", a_cnt[0], 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
